// File: rtl/fc_layer_par_if.sv
// Bus bundle for fc_layer_par: control, memory read ports and output write port.
// The master side owns start/config and the memories; the slave is the layer.
interface fc_layer_par_if #(
  parameter int IN_DIM  = 784,
  parameter int OUT_DIM = 32,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8
);
  localparam int G  = OUT_DIM / LANES;
  localparam int XW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int WW = (G * IN_DIM > 1) ? $clog2(G * IN_DIM) : 1;
  localparam int BW = (G > 1) ? $clog2(G) : 1;
  localparam int YW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  logic                     start;
  logic                     busy;
  logic                     done;
  logic [5:0]               shift_right;
  logic                     round_en;
  logic                     relu_en;
  logic [XW-1:0]            x_addr;
  logic [7:0]               x_data;
  logic [WW-1:0]            w_addr;
  logic [8*LANES-1:0]       w_data;
  logic [BW-1:0]            b_addr;
  logic [ACC_W*LANES-1:0]   b_data;
  logic                     y_we;
  logic [YW-1:0]            y_addr;
  logic [OUT_W-1:0]         y_data;

  modport master (
    output start, shift_right, round_en, relu_en,
    output x_data, w_data, b_data,
    input  busy, done, x_addr, w_addr, b_addr,
    input  y_we, y_addr, y_data
  );

  modport slave (
    input  start, shift_right, round_en, relu_en,
    input  x_data, w_data, b_data,
    output busy, done, x_addr, w_addr, b_addr,
    output y_we, y_addr, y_data
  );
endinterface

// File: rtl/fc_layer_par.sv
// Fully-connected layer: LANES neurons per pass, serial over inputs,
// bias-initialised MAC, rounding shift, saturation, optional ReLU.
module fc_layer_par #(
  parameter int IN_DIM  = 784,
  parameter int OUT_DIM = 32,
  parameter int LANES   = 4,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8
) (
  input logic           clk,
  input logic           rst,
  fc_layer_par_if.slave bus
);
  localparam int G  = OUT_DIM / LANES;
  localparam int XW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int BW = (G > 1) ? $clog2(G) : 1;
  localparam int YW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic signed [ACC_W-1:0] YMAX =
    ACC_W'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] YMIN = ~YMAX;

  typedef enum logic [2:0] {
    IDLE, ISSUE, MAC, DRAIN, DONE
  } state_t;

  state_t        st;
  logic [XW-1:0] k;
  logic [BW-1:0] g;
  logic [LW-1:0] l;
  logic [YW-1:0] n;

  logic signed [ACC_W-1:0] acc     [LANES];
  logic signed [ACC_W-1:0] base    [LANES];
  logic signed [ACC_W-1:0] mac_nxt [LANES];
  logic signed [15:0]      prod    [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod[i] = $signed(bus.w_data[8*i +: 8]) *
                $signed(bus.x_data);
      base[i] = (k == '0) ?
        $signed(bus.b_data[ACC_W*i +: ACC_W]) : acc[i];
      mac_nxt[i] = base[i] + ACC_W'(prod[i]);
    end
  end

  logic [5:0]              s_eff;
  logic signed [ACC_W-1:0] sel;
  logic signed [ACC_W-1:0] rnd;
  logic signed [ACC_W-1:0] t;
  logic signed [ACC_W-1:0] r;
  logic [OUT_W-1:0]        res;

  // Post-processing of the lane currently being drained.
  always_comb begin
    s_eff = (32'(bus.shift_right) >= ACC_W) ?
      6'(ACC_W - 1) : bus.shift_right;
    sel = acc[l];
    rnd = '0;
    if (bus.round_en && s_eff != 6'd0)
      rnd = ACC_W'(1) << (s_eff - 6'd1);
    t = sel + rnd;
    r = t >>> s_eff;
    if (r > YMAX)
      res = YMAX[OUT_W-1:0];
    else if (r < YMIN)
      res = YMIN[OUT_W-1:0];
    else
      res = r[OUT_W-1:0];
    if (bus.relu_en && res[OUT_W-1])
      res = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      k           <= '0;
      g           <= '0;
      l           <= '0;
      n           <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.y_we    <= 1'b0;
      bus.x_addr  <= '0;
      bus.w_addr  <= '0;
      bus.b_addr  <= '0;
      bus.y_addr  <= '0;
      bus.y_data  <= '0;
      for (int i = 0; i < LANES; i++)
        acc[i] <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.y_we <= 1'b0;
      unique case (st)
        IDLE: begin
          if (bus.start) begin
            st         <= ISSUE;
            bus.busy   <= 1'b1;
            g          <= '0;
            n          <= '0;
            bus.x_addr <= '0;
            bus.w_addr <= '0;
            bus.b_addr <= '0;
          end
        end
        ISSUE: begin
          st <= MAC;
          k  <= '0;
          if (IN_DIM > 1) begin
            bus.x_addr <= bus.x_addr + 1'b1;
            bus.w_addr <= bus.w_addr + 1'b1;
          end
        end
        MAC: begin
          for (int i = 0; i < LANES; i++)
            acc[i] <= mac_nxt[i];
          // Address bus runs one element ahead of the data.
          if (32'(k) + 32'd2 < 32'(IN_DIM)) begin
            bus.x_addr <= bus.x_addr + 1'b1;
            bus.w_addr <= bus.w_addr + 1'b1;
          end
          if (32'(k) == 32'(IN_DIM - 1)) begin
            st <= DRAIN;
            l  <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        DRAIN: begin
          bus.y_we   <= 1'b1;
          bus.y_addr <= n;
          bus.y_data <= res;
          n          <= n + 1'b1;
          if (32'(l) == 32'(LANES - 1)) begin
            if (32'(g) == 32'(G - 1)) begin
              st       <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              st         <= ISSUE;
              g          <= g + 1'b1;
              bus.b_addr <= g + 1'b1;
              bus.x_addr <= '0;
              bus.w_addr <= bus.w_addr + 1'b1;
            end
          end else begin
            l <= l + 1'b1;
          end
        end
        DONE: begin
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fc_layer_par.sv
// Bench for fc_layer_par: small 4/4/2 instance for directed cases,
// default 784/32/4 instance for a full-size random run.
module tb_fc_layer_par;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  fc_layer_par_if #(.IN_DIM(4), .OUT_DIM(4), .LANES(2)) s_if ();
  fc_layer_par_if b_if ();

  fc_layer_par #(.IN_DIM(4), .OUT_DIM(4), .LANES(2)) u_small (
    .clk (clk),
    .rst (rst_s),
    .bus (s_if.slave)
  );

  fc_layer_par u_big (
    .clk (clk),
    .rst (rst_b),
    .bus (b_if.slave)
  );

  byte xs [4];
  byte ws [4][4];
  int  bs [4];
  int  ey_s [4];

  byte xb [784];
  byte wb [32][784];
  int  bb [32];
  int  ey_b [32];

  always_ff @(posedge clk) begin
    s_if.x_data <= xs[int'(s_if.x_addr)];
    for (int ln = 0; ln < 2; ln++) begin
      s_if.w_data[8*ln +: 8] <=
        ws[(int'(s_if.w_addr) / 4) * 2 + ln][int'(s_if.w_addr) % 4];
      s_if.b_data[32*ln +: 32] <= bs[int'(s_if.b_addr) * 2 + ln];
    end
  end

  always_ff @(posedge clk) begin
    b_if.x_data <= xb[int'(b_if.x_addr)];
    for (int ln = 0; ln < 4; ln++) begin
      b_if.w_data[8*ln +: 8] <=
        wb[(int'(b_if.w_addr) / 784) * 4 + ln][int'(b_if.w_addr) % 784];
      b_if.b_data[32*ln +: 32] <= bb[int'(b_if.b_addr) * 4 + ln];
    end
  end

  typedef struct {
    byte x; byte w; int b; int sh; bit rnd; bit relu; int y;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int golden(int acc, int sh, bit rnd, bit relu);
    int s;
    int t;
    int r;
    s = (sh > 31) ? 31 : sh;
    t = acc;
    if (rnd && s > 0) t = t + (1 << (s - 1));
    r = t >>> s;
    if (r > 127) r = 127;
    else if (r < -128) r = -128;
    if (relu && r < 0) r = 0;
    return r;
  endfunction

  task automatic model_small(input int sh, input bit rnd, input bit relu);
    int a;
    for (int o = 0; o < 4; o++) begin
      a = bs[o];
      for (int kk = 0; kk < 4; kk++) a += int'(ws[o][kk]) * int'(xs[kk]);
      ey_s[o] = golden(a, sh, rnd, relu);
    end
  endtask

  task automatic set_mode(input int sh, input bit rnd, input bit relu);
    s_if.shift_right = 6'(sh);
    s_if.round_en    = rnd;
    s_if.relu_en     = relu;
  endtask

  task automatic load_uniform(input byte x, input byte w, input int b);
    for (int o = 0; o < 4; o++) begin
      xs[o] = x;
      bs[o] = b;
      for (int kk = 0; kk < 4; kk++) ws[o][kk] = w;
    end
  endtask

  task automatic run_small(input string nm, input bit poke);
    int  cyc;
    int  nw;
    int  done_at;
    bit  busy_ok;
    @(negedge clk);
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    cyc = 1; nw = 0; done_at = -1; busy_ok = 1'b1;
    while (cyc < 60 && done_at < 0) begin
      s_if.start = poke && (cyc == 5);
      if (s_if.busy !== (cyc < 15)) busy_ok = 1'b0;
      if (s_if.y_we === 1'b1) begin
        if (nw < 4) begin
          chk({nm, " y_addr"}, longint'(s_if.y_addr), nw);
          chk({nm, " y_data"}, $signed(s_if.y_data), ey_s[nw]);
        end
        nw++;
      end
      if (s_if.done === 1'b1) done_at = cyc;
      @(negedge clk);
      cyc++;
    end
    s_if.start = 1'b0;
    chk({nm, " done cycle"}, done_at, 15);
    chk({nm, " write count"}, nw, 4);
    chk({nm, " busy window"}, busy_ok, 1);
    chk({nm, " done pulse end"}, s_if.done, 0);
  endtask

  initial begin
    int  cyc;
    int  nw;
    int  done_at;
    int  a;
    bit  flag;

    tbl[0] = '{x: 1,   w: 1,    b: 0,  sh: 0,  rnd: 0, relu: 0, y: 4};
    tbl[1] = '{x: 127, w: 127,  b: 0,  sh: 0,  rnd: 0, relu: 0, y: 127};
    tbl[2] = '{x: 127, w: -127, b: 0,  sh: 0,  rnd: 0, relu: 0, y: -128};
    tbl[3] = '{x: 127, w: -127, b: 0,  sh: 0,  rnd: 0, relu: 1, y: 0};
    tbl[4] = '{x: 5,   w: 0,    b: 6,  sh: 2,  rnd: 0, relu: 0, y: 1};
    tbl[5] = '{x: 5,   w: 0,    b: 6,  sh: 2,  rnd: 1, relu: 0, y: 2};
    tbl[6] = '{x: 5,   w: 0,    b: -6, sh: 2,  rnd: 0, relu: 0, y: -2};
    tbl[7] = '{x: 5,   w: 0,    b: -6, sh: 2,  rnd: 1, relu: 0, y: -1};
    tbl[8] = '{x: 5,   w: 0,    b: -6, sh: 40, rnd: 0, relu: 0, y: -1};

    rst_s = 1'b1;
    rst_b = 1'b1;
    s_if.start = 1'b0;
    b_if.start = 1'b0;
    set_mode(0, 0, 0);
    b_if.shift_right = 6'd0;
    b_if.round_en    = 1'b0;
    b_if.relu_en     = 1'b0;
    load_uniform(0, 0, 0);
    repeat (3) @(negedge clk);
    chk("reset busy",   s_if.busy,   0);
    chk("reset done",   s_if.done,   0);
    chk("reset y_we",   s_if.y_we,   0);
    chk("reset x_addr", s_if.x_addr, 0);
    chk("reset w_addr", s_if.w_addr, 0);
    chk("reset b_addr", s_if.b_addr, 0);
    chk("reset y_addr", s_if.y_addr, 0);
    chk("reset y_data", s_if.y_data, 0);
    rst_s = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 9; i++) begin
      load_uniform(tbl[i].x, tbl[i].w, tbl[i].b);
      set_mode(tbl[i].sh, tbl[i].rnd, tbl[i].relu);
      for (int o = 0; o < 4; o++) ey_s[o] = tbl[i].y;
      run_small($sformatf("vec%0d", i), 1'b0);
    end

    // Distinct lanes, with neuron 0 wrapping past 2^31-1.
    for (int kk = 0; kk < 4; kk++) begin
      xs[kk] = byte'($urandom_range(1, 127));
      ws[0][kk] = 8'sd100;
      for (int o = 1; o < 4; o++)
        ws[o][kk] = byte'($urandom_range(0, 255));
    end
    bs[0] = 32'h7fff_ffff;
    bs[1] = 32'h8000_0000;
    bs[2] = int'($urandom_range(0, 2000)) - 1000;
    bs[3] = int'($urandom_range(0, 2000)) - 1000;
    set_mode(4, 1, 0);
    model_small(4, 1, 0);
    run_small("lanes", 1'b0);
    set_mode(0, 0, 1);
    model_small(0, 0, 1);
    run_small("lanes relu", 1'b0);

    load_uniform(1, 1, 0);
    set_mode(0, 0, 0);
    for (int o = 0; o < 4; o++) ey_s[o] = 4;
    run_small("start while busy", 1'b1);

    @(negedge clk);
    s_if.start = 1'b1;
    @(negedge clk);
    s_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;
    chk("abort busy", s_if.busy, 0);
    chk("abort y_we", s_if.y_we, 0);
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (s_if.y_we || s_if.done || s_if.busy) flag = 1'b1;
    end
    chk("abort quiet", flag, 0);
    run_small("after abort", 1'b0);

    for (int kk = 0; kk < 784; kk++) begin
      xb[kk] = byte'($urandom_range(0, 255));
      for (int o = 0; o < 32; o++)
        wb[o][kk] = byte'($urandom_range(0, 255));
    end
    for (int o = 0; o < 32; o++)
      bb[o] = int'($urandom_range(0, 20000)) - 10000;
    for (int o = 0; o < 32; o++) begin
      a = bb[o];
      for (int kk = 0; kk < 784; kk++) a += int'(wb[o][kk]) * int'(xb[kk]);
      ey_b[o] = golden(a, 12, 1'b1, 1'b0);
    end
    b_if.shift_right = 6'd12;
    b_if.round_en    = 1'b1;
    b_if.relu_en     = 1'b0;
    @(negedge clk);
    b_if.start = 1'b1;
    @(negedge clk);
    b_if.start = 1'b0;
    cyc = 1; nw = 0; done_at = -1;
    while (cyc < 7000 && done_at < 0) begin
      if (b_if.y_we === 1'b1) begin
        if (nw < 32) begin
          chk($sformatf("big y_addr %0d", nw), longint'(b_if.y_addr), nw);
          chk($sformatf("big y_data %0d", nw), $signed(b_if.y_data), ey_b[nw]);
        end
        nw++;
      end
      if (b_if.done === 1'b1) done_at = cyc;
      @(negedge clk);
      cyc++;
    end
    chk("big done cycle", done_at, 6313);
    chk("big write count", nw, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
